// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / stall controller.
//
// Compares the ID-stage source register indices against the EX and MEM
// destination registers. It also watches the cache busy line, taken
// branches and halt. From these it drives hold (stall) and bubble (flush)
// controls for PC, IF_ID, ID_EX and EX_MEM.
//
// The state machine has four states: RUN, MEM_WAIT, DRAIN and HALTED.
// The state is registered. The stall and flush outputs are combinational
// from state and inputs, so the pipeline sees a response in the same cycle.
//
// Configuration macro: HAZARD_FORWARD_EN
//   defined   - EX/MEM forwarding exists; stall only on load-use.
//   undefined - no forwarding; stall on any RAW against EX or MEM.
//
// Parameters:
//   DRAIN_CYCLES  cycles spent in DRAIN after halt reaches EX
//   MAX_WAIT      MEM_WAIT count at which mem_timeout sets
//   WAIT_W        width of the wait counter
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   id_rs_idx/id_rt_idx           ID-stage source indices
//   id_rs_used/id_rt_used         ID-stage source read enables
//   w1_reg_ID_EX, reg_en_ID_EX    EX-stage destination and write enable
//   mem_en_ID_EX, mem_wr_ID_EX    EX-stage memory access / store flag
//   halt_ID_EX                    halt instruction in EX
//   w1_reg_EX_MEM, reg_en_EX_MEM  MEM-stage destination and write enable
//   branch_taken                  EX resolved a taken branch/jump
//   mem_busy                      cache not ready this cycle
//   pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
//   ex_mem_stall                  pipeline hold / bubble controls
//   halt_out                      processor halted (sticky)
//   mem_timeout                   a memory wait reached MAX_WAIT (sticky)
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned MAX_WAIT     = 15,
  parameter int unsigned WAIT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] id_rs_idx,
  input  logic [2:0] id_rt_idx,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [2:0] w1_reg_ID_EX,
  input  logic       reg_en_ID_EX,
  input  logic       mem_en_ID_EX,
  input  logic       mem_wr_ID_EX,
  input  logic       halt_ID_EX,
  input  logic [2:0] w1_reg_EX_MEM,
  input  logic       reg_en_EX_MEM,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       halt_out,
  output logic       mem_timeout
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM   = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DW-1:0]     drain_cnt;

  logic raw_ex;
  logic raw_mem;
  logic load_use;
  logic data_hazard;

  // Index 0 is deliberately not special: a match on r0 still counts.
  assign raw_ex  = reg_en_ID_EX &
                   ((id_rs_used & (id_rs_idx == w1_reg_ID_EX)) |
                    (id_rt_used & (id_rt_idx == w1_reg_ID_EX)));
  assign raw_mem = reg_en_EX_MEM &
                   ((id_rs_used & (id_rs_idx == w1_reg_EX_MEM)) |
                    (id_rt_used & (id_rt_idx == w1_reg_EX_MEM)));
  assign load_use = raw_ex & mem_en_ID_EX & ~mem_wr_ID_EX;

`ifdef HAZARD_FORWARD_EN
  assign data_hazard = load_use;
`else
  assign data_hazard = raw_ex | raw_mem;
`endif

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mem_busy) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
          end else if (halt_ID_EX) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (data_hazard) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_busy) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
          end
        end
        DRAIN: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (mem_busy) begin
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
          end
        end
        HALTED: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // DRAIN absorbs mem_busy itself (counter holds), so MEM_WAIT is only ever
  // entered from RUN and always returns there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      drain_cnt   <= '0;
      halt_out    <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_busy) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else if (halt_ID_EX) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt == WAIT_LIM) mem_timeout <= 1'b1;
          if (mem_busy) begin
            if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            if (drain_cnt == DRAIN_LAST) begin
              state    <= HALTED;
              halt_out <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DW'(1);
            end
          end
        end
        HALTED: halt_out <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int DRAIN_CYCLES = 2;
  localparam int MAX_WAIT     = 15;
  localparam int WAIT_SAT     = 15;

  // Output vector bit order:
  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  //  ex_mem_stall, halt_out, mem_timeout}
  localparam logic [7:0] ZERO   = 8'b0000_0000;
  localparam logic [7:0] HAZ    = 8'b1100_1000;
  localparam logic [7:0] STALL4 = 8'b1101_0100;
  localparam logic [7:0] BR     = 8'b0010_1000;
  localparam logic [7:0] DBUSY  = 8'b1101_1100;
  localparam logic [7:0] HALTV  = 8'b1100_1010;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs_idx, id_rt_idx, w1_reg_ID_EX, w1_reg_EX_MEM;
  logic       id_rs_used, id_rt_used, reg_en_ID_EX, mem_en_ID_EX, mem_wr_ID_EX;
  logic       halt_ID_EX, reg_en_EX_MEM, branch_taken, mem_busy;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, halt_out, mem_timeout;
  logic [7:0] obs;

  int total = 0;
  int bad   = 0;

  // Reference model: phase flags plus remaining-cycle counters.
  bit m_halted, m_waiting, m_timeout;
  int m_wait_len, m_drain_left;

  always #5 clk = ~clk;

  assign obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, halt_out, mem_timeout};

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .w1_reg_ID_EX(w1_reg_ID_EX), .reg_en_ID_EX(reg_en_ID_EX),
    .mem_en_ID_EX(mem_en_ID_EX), .mem_wr_ID_EX(mem_wr_ID_EX),
    .halt_ID_EX(halt_ID_EX), .w1_reg_EX_MEM(w1_reg_EX_MEM),
    .reg_en_EX_MEM(reg_en_EX_MEM), .branch_taken(branch_taken),
    .mem_busy(mem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .halt_out(halt_out), .mem_timeout(mem_timeout)
  );

  task automatic clr_in();
    id_rs_idx = '0; id_rt_idx = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    w1_reg_ID_EX = '0; reg_en_ID_EX = 1'b0; mem_en_ID_EX = 1'b0;
    mem_wr_ID_EX = 1'b0; halt_ID_EX = 1'b0; w1_reg_EX_MEM = '0;
    reg_en_EX_MEM = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_halted = 0; m_waiting = 0; m_timeout = 0;
    m_wait_len = 0; m_drain_left = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clr_in();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  function automatic bit reads(input logic [2:0] idx);
    return (id_rs_used && id_rs_idx == idx) || (id_rt_used && id_rt_idx == idx);
  endfunction

  function automatic logic [7:0] model_out();
    bit hz;
    logic [7:0] v;
`ifdef HAZARD_FORWARD_EN
    hz = reg_en_ID_EX && mem_en_ID_EX && !mem_wr_ID_EX && reads(w1_reg_ID_EX);
`else
    hz = (reg_en_ID_EX && reads(w1_reg_ID_EX)) ||
         (reg_en_EX_MEM && reads(w1_reg_EX_MEM));
`endif
    if (m_halted)              v = HAZ;
    else if (m_drain_left > 0) v = mem_busy ? DBUSY : HAZ;
    else if (m_waiting)        v = mem_busy ? STALL4 : ZERO;
    else if (mem_busy)         v = STALL4;
    else if (halt_ID_EX)       v = HAZ;
    else if (branch_taken)     v = BR;
    else if (hz)               v = HAZ;
    else                       v = ZERO;
    v[1] = m_halted;
    v[0] = m_timeout;
    return v;
  endfunction

  task automatic model_step();
    if (m_halted) begin
    end else if (m_drain_left > 0) begin
      if (!mem_busy) begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1;
      end
    end else if (m_waiting) begin
      if (m_wait_len >= MAX_WAIT) m_timeout = 1;
      if (mem_busy) m_wait_len = (m_wait_len + 1 > WAIT_SAT) ? WAIT_SAT : m_wait_len + 1;
      else begin m_waiting = 0; m_wait_len = 0; end
    end else if (mem_busy) begin
      m_waiting = 1; m_wait_len = 1;
    end else if (halt_ID_EX) begin
      m_drain_left = DRAIN_CYCLES;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_in();
    mem_busy = 1'b1; halt_ID_EX = 1'b1;
    #1;
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL rst_hold got=%b exp=%b", obs, ZERO); end
    tick();
    rst = 1'b0;
    clr_in();
    #1;
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL rst_idle got=%b exp=%b", obs, ZERO); end
    tick();
  endtask

  task automatic test_load_use();
    logic [7:0] exp2;
    apply_reset();
    reg_en_ID_EX = 1'b1; mem_en_ID_EX = 1'b1; w1_reg_ID_EX = 3'd3;
    id_rs_idx = 3'd3; id_rs_used = 1'b1;
    #1;
    total++;
    if (obs !== HAZ) begin bad++; $display("FAIL ld_use_c1 got=%b exp=%b", obs, HAZ); end
    tick();
    // bubble now in EX, load in MEM
    reg_en_ID_EX = 1'b0; mem_en_ID_EX = 1'b0;
    reg_en_EX_MEM = 1'b1; w1_reg_EX_MEM = 3'd3;
`ifdef HAZARD_FORWARD_EN
    exp2 = ZERO;
`else
    exp2 = HAZ;
`endif
    #1;
    total++;
    if (obs !== exp2) begin bad++; $display("FAIL ld_use_c2 got=%b exp=%b", obs, exp2); end
    tick();
    // a store with matching destination is not a load-use
    clr_in();
    reg_en_ID_EX = 1'b1; mem_en_ID_EX = 1'b1; mem_wr_ID_EX = 1'b1;
    w1_reg_ID_EX = 3'd4; id_rt_idx = 3'd4; id_rt_used = 1'b1;
`ifdef HAZARD_FORWARD_EN
    exp2 = ZERO;
`else
    exp2 = HAZ;
`endif
    #1;
    total++;
    if (obs !== exp2) begin bad++; $display("FAIL store_match got=%b exp=%b", obs, exp2); end
    tick();
  endtask

  task automatic test_alu_raw();
    logic [7:0] e;
`ifdef HAZARD_FORWARD_EN
    e = ZERO;
`else
    e = HAZ;
`endif
    apply_reset();
    reg_en_ID_EX = 1'b1; w1_reg_ID_EX = 3'd2; id_rt_idx = 3'd2; id_rt_used = 1'b1;
    #1;
    total++;
    if (obs !== e) begin bad++; $display("FAIL alu_raw_ex got=%b exp=%b", obs, e); end
    tick();
    reg_en_ID_EX = 1'b0; reg_en_EX_MEM = 1'b1; w1_reg_EX_MEM = 3'd2;
    #1;
    total++;
    if (obs !== e) begin bad++; $display("FAIL alu_raw_mem got=%b exp=%b", obs, e); end
    tick();
    reg_en_EX_MEM = 1'b0;
    #1;
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL alu_raw_clear got=%b exp=%b", obs, ZERO); end
    tick();
    // unused source never stalls
    clr_in();
    reg_en_ID_EX = 1'b1; mem_en_ID_EX = 1'b1; w1_reg_ID_EX = 3'd6; id_rs_idx = 3'd6;
    #1;
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL unused_src got=%b exp=%b", obs, ZERO); end
    tick();
    // r0 is an ordinary register
    id_rs_idx = 3'd0; w1_reg_ID_EX = 3'd0; id_rs_used = 1'b1;
    #1;
    total++;
    if (obs !== HAZ) begin bad++; $display("FAIL r0_match got=%b exp=%b", obs, HAZ); end
    tick();
  endtask

  task automatic test_mem_wait();
    apply_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (obs !== STALL4) begin bad++; $display("FAIL busy4_c%0d got=%b exp=%b", i, obs, STALL4); end
      tick();
    end
    mem_busy = 1'b0;
    #1;
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL busy4_exit got=%b exp=%b", obs, ZERO); end
    tick();
    reg_en_ID_EX = 1'b1; mem_en_ID_EX = 1'b1; w1_reg_ID_EX = 3'd5;
    id_rs_idx = 3'd5; id_rs_used = 1'b1;
    #1;
    total++;
    if (obs !== HAZ) begin bad++; $display("FAIL back_in_run got=%b exp=%b", obs, HAZ); end
    tick();
    clr_in();
    mem_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      total++;
      if (obs !== STALL4) begin bad++; $display("FAIL busy16_c%0d got=%b exp=%b", i, obs, STALL4); end
      tick();
    end
    mem_busy = 1'b0;
    #1;
    total++;
    if (obs !== 8'b0000_0001) begin bad++; $display("FAIL timeout_set got=%b exp=%b", obs, 8'b0000_0001); end
    tick();
    #1;
    total++;
    if (obs !== 8'b0000_0001) begin bad++; $display("FAIL timeout_sticky got=%b exp=%b", obs, 8'b0000_0001); end
    tick();
  endtask

  task automatic test_branch();
    apply_reset();
    branch_taken = 1'b1;
    reg_en_ID_EX = 1'b1; mem_en_ID_EX = 1'b1; w1_reg_ID_EX = 3'd1;
    id_rs_idx = 3'd1; id_rs_used = 1'b1;
    #1;
    total++;
    if (obs !== BR) begin bad++; $display("FAIL br_over_ld got=%b exp=%b", obs, BR); end
    tick();
    clr_in();
    branch_taken = 1'b1; mem_busy = 1'b1;
    #1;
    total++;
    if (obs !== STALL4) begin bad++; $display("FAIL br_busy got=%b exp=%b", obs, STALL4); end
    tick();
    mem_busy = 1'b0;
    #1;
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL br_in_wait got=%b exp=%b", obs, ZERO); end
    tick();
    #1;
    total++;
    if (obs !== BR) begin bad++; $display("FAIL br_after_wait got=%b exp=%b", obs, BR); end
    tick();
  endtask

  task automatic test_halt();
    apply_reset();
    halt_ID_EX = 1'b1;
    #1;
    total++;
    if (obs !== HAZ) begin bad++; $display("FAIL halt_run got=%b exp=%b", obs, HAZ); end
    tick();
    halt_ID_EX = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (obs !== HAZ) begin bad++; $display("FAIL drain_c%0d got=%b exp=%b", i, obs, HAZ); end
      tick();
    end
    branch_taken = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (obs !== HALTV) begin bad++; $display("FAIL halted_c%0d got=%b exp=%b", i, obs, HALTV); end
      tick();
    end
    apply_reset();
    halt_ID_EX = 1'b1;
    tick();
    halt_ID_EX = 1'b0; mem_busy = 1'b1;
    #1;
    total++;
    if (obs !== DBUSY) begin bad++; $display("FAIL drain_busy got=%b exp=%b", obs, DBUSY); end
    tick();
    mem_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (obs !== HAZ) begin bad++; $display("FAIL drain_ext_c%0d got=%b exp=%b", i, obs, HAZ); end
      tick();
    end
    #1;
    total++;
    if (obs !== HALTV) begin bad++; $display("FAIL halted_ext got=%b exp=%b", obs, HALTV); end
    tick();
  endtask

  task automatic test_rst_mid_wait();
    apply_reset();
    mem_busy = 1'b1;
    repeat (17) tick();
    #1;
    total++;
    if (obs !== 8'b1101_0101) begin bad++; $display("FAIL pre_rst got=%b exp=%b", obs, 8'b1101_0101); end
    rst = 1'b1;
    #1;
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL async_rst got=%b exp=%b", obs, ZERO); end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (obs !== STALL4) begin bad++; $display("FAIL rst_to_run got=%b exp=%b", obs, STALL4); end
    tick();
    mem_busy = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int burst = 0;
    int halted_cycles = 0;
    logic [7:0] e;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_halted) halted_cycles++;
      if (halted_cycles > 3) begin apply_reset(); halted_cycles = 0; end
      id_rs_idx     = 3'($urandom_range(0, 3));
      id_rt_idx     = 3'($urandom_range(0, 3));
      id_rs_used    = 1'($urandom_range(0, 1));
      id_rt_used    = 1'($urandom_range(0, 1));
      w1_reg_ID_EX  = 3'($urandom_range(0, 3));
      reg_en_ID_EX  = 1'($urandom_range(0, 1));
      mem_en_ID_EX  = 1'($urandom_range(0, 1));
      mem_wr_ID_EX  = 1'($urandom_range(0, 1));
      w1_reg_EX_MEM = 3'($urandom_range(0, 3));
      reg_en_EX_MEM = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 5) == 0);
      halt_ID_EX    = ($urandom_range(0, 59) == 0);
      if (burst == 0 && $urandom_range(0, 7) == 0)
        burst = ($urandom_range(0, 9) == 0) ? 18 : int'($urandom_range(1, 5));
      mem_busy = (burst > 0);
      if (burst > 0) burst--;
      #1;
      e = model_out();
      total++;
      if (obs !== e) begin bad++; $display("FAIL rand_c%0d got=%b exp=%b", i, obs, e); end
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    model_reset();
    test_reset();
    test_load_use();
    test_alu_raw();
    test_mem_wait();
    test_branch();
    test_halt();
    test_rst_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
